// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, including the
// multi-cycle MDU busy sequencer and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_taken,
    input  logic             id_mdu_start,
    input  logic             id_rd_hilo,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_wn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_wn,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mdu_go,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic w_load_use, w_br_haz, w_mdu_haz, w_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // EX hits take priority: the EX result is the youngest value of the register.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit && ex_wreg && !ex_m2reg)
            return 2'b01;
        else if (mem_hit && mem_wreg)
            return mem_m2reg ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    // r0 is hardwired to zero, so it never creates a dependency.
    assign w_ex_rs  = id_use_rs && (id_rs != 5'd0) && (id_rs == ex_wn);
    assign w_ex_rt  = id_use_rt && (id_rt != 5'd0) && (id_rt == ex_wn);
    assign w_mem_rs = id_use_rs && (id_rs != 5'd0) && (id_rs == mem_wn);
    assign w_mem_rt = id_use_rt && (id_rt != 5'd0) && (id_rt == mem_wn);

    assign w_load_use = ex_wreg && ex_m2reg && (w_ex_rs || w_ex_rt);
    assign w_br_haz   = id_is_branch && ex_wreg && (w_ex_rs || w_ex_rt);
    assign w_mdu_haz  = (r_state == S_BUSY) && (id_mdu_start || id_rd_hilo);
    assign w_stall    = w_load_use || w_br_haz || w_mdu_haz;

    assign fwda       = fwd_sel(w_ex_rs, w_mem_rs);
    assign fwdb       = fwd_sel(w_ex_rt, w_mem_rt);
    assign pc_en      = !w_stall;
    assign ifid_en    = !w_stall;
    assign idex_en    = !w_stall;
    assign ifid_flush = !w_stall && id_taken;
    assign mdu_go     = !w_stall && id_mdu_start && (r_state == S_IDLE);
    assign mdu_busy   = (r_state == S_BUSY);
    assign stall_cnt  = r_stall_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (mdu_go) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = LAT_M1;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model
// that tracks remaining MDU busy cycles and the stall count as plain integers.
module tb_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             clrn;
    logic [4:0]       id_rs, id_rt, ex_wn, mem_wn;
    logic             id_use_rs, id_use_rt, id_is_branch, id_taken;
    logic             id_mdu_start, id_rd_hilo;
    logic             ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic             pc_en, ifid_en, ifid_flush, idex_en, mdu_go, mdu_busy;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n_go   = 0;

    int m_busy = 0;
    int m_cnt  = 0;
    bit e_stall, e_go;
    int e_fwda, e_fwdb;

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_taken(id_taken),
        .id_mdu_start(id_mdu_start), .id_rd_hilo(id_rd_hilo),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wn(ex_wn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .fwda(fwda), .fwdb(fwdb), .mdu_go(mdu_go), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] r, input logic u, input logic [4:0] dst);
        return u && (r != 0) && (r == dst);
    endfunction

    function automatic int m_fwd(input logic [4:0] r, input logic u);
        if (hit(r, u, ex_wn) && ex_wreg && !ex_m2reg) return 1;
        if (hit(r, u, mem_wn) && mem_wreg) return mem_m2reg ? 3 : 2;
        return 0;
    endfunction

    task automatic model_eval();
        bit dep_ex;
        dep_ex  = hit(id_rs, id_use_rs, ex_wn) || hit(id_rt, id_use_rt, ex_wn);
        e_stall = (ex_wreg && ex_m2reg && dep_ex) ||
                  (id_is_branch && ex_wreg && dep_ex) ||
                  ((m_busy > 0) && (id_mdu_start || id_rd_hilo));
        e_go    = !e_stall && id_mdu_start && (m_busy == 0);
        e_fwda  = m_fwd(id_rs, id_use_rs);
        e_fwdb  = m_fwd(id_rt, id_use_rt);
    endtask

    // Called at posedge+1 with inputs already applied; checks, then advances one cycle.
    task automatic step();
        #2;
        model_eval();
        chk("pc_en",    pc_en,      !e_stall);
        chk("ifid_en",  ifid_en,    !e_stall);
        chk("idex_en",  idex_en,    !e_stall);
        chk("flush",    ifid_flush, !e_stall && id_taken);
        chk("fwda",     fwda,       e_fwda);
        chk("fwdb",     fwdb,       e_fwdb);
        chk("mdu_go",   mdu_go,     e_go);
        chk("mdu_busy", mdu_busy,   m_busy > 0);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (mdu_go) n_go++;
        @(posedge clk);
        if (e_stall && m_cnt < CNT_MAX) m_cnt++;
        if (m_busy > 0) m_busy--;
        if (e_go) m_busy = MDU_LAT;
        #1;
    endtask

    task automatic idle_in();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_branch = 0; id_taken = 0; id_mdu_start = 0; id_rd_hilo = 0;
        ex_wreg = 0; ex_m2reg = 0; ex_wn = 0;
        mem_wreg = 0; mem_m2reg = 0; mem_wn = 0;
    endtask

    // Asynchronous reset dropped mid-cycle; effect must be visible before any edge.
    task automatic do_reset(input string tag);
        clrn = 1'b0;
        #1;
        chk({tag, "_busy"}, mdu_busy, 0);
        chk({tag, "_cnt"},  stall_cnt, 0);
        m_busy = 0; m_cnt = 0;
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        clrn = 1'b0;
        #2;
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_idex_en", idex_en, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_fwd", {fwda, fwdb}, 0);
        chk("rst_go", mdu_go, 0);
        chk("rst_busy", mdu_busy, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // Load-use then forwarding from the load data one cycle later
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 5; id_rs = 5; id_use_rs = 1;
        step();
        ex_wreg = 0; ex_m2reg = 0; ex_wn = 0;
        mem_wreg = 1; mem_m2reg = 1; mem_wn = 5;
        step();
        chk("lu_fwda", fwda, 3);
        chk("lu_cnt", stall_cnt, 1);

        // Forwarding priority and r0 exclusion
        idle_in();
        ex_wn = 8; mem_wn = 8; ex_wreg = 1; mem_wreg = 1; id_rt = 8; id_use_rt = 1;
        step();
        chk("prio_fwdb", fwdb, 1);
        id_rt = 0; ex_wn = 0; mem_wn = 0;
        step();
        chk("r0_fwdb", fwdb, 0);

        // Branch: plain flush, then stall overriding flush, then flush
        idle_in();
        id_taken = 1;
        step();
        id_is_branch = 1; ex_wreg = 1; ex_wn = 3; id_rs = 3; id_use_rs = 1;
        step();
        ex_wreg = 0;
        step();

        // MDU issue followed by mfhi held through the busy window
        idle_in();
        do_reset("r1");
        id_mdu_start = 1;
        step();
        id_mdu_start = 0; id_rd_hilo = 1;
        repeat (MDU_LAT + 1) step();
        chk("mdu_cnt", stall_cnt, MDU_LAT);

        // Back-to-back MDU ops
        idle_in();
        do_reset("r2");
        n_go = 0;
        id_mdu_start = 1;
        repeat (MDU_LAT + 2) step();
        chk("b2b_go", n_go, 2);
        chk("b2b_cnt", stall_cnt, MDU_LAT);

        // Async reset on the second busy cycle with a nonzero stall count
        idle_in();
        do_reset("r3");
        id_mdu_start = 1;
        step();
        id_mdu_start = 0; id_rd_hilo = 1;
        step();
        id_rd_hilo = 0;
        do_reset("r_mid");
        chk("r_mid_pc_en", pc_en, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_wn = 5'($urandom_range(0, 3)); mem_wn = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom);
            mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom);
            id_is_branch = ($urandom_range(0, 3) == 0);
            id_taken = ($urandom_range(0, 3) == 0);
            id_mdu_start = ($urandom_range(0, 5) == 0);
            id_rd_hilo = ($urandom_range(0, 5) == 0);
            step();
        end

        // Saturation of the stall counter
        idle_in();
        do_reset("r4");
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 9; id_rt = 9; id_use_rt = 1;
        repeat (CNT_MAX + 4) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt, CNT_MAX);
        chk("sat_pc_en", pc_en, 0);
        m_cnt = CNT_MAX;
        step();
        chk("sat_hold", stall_cnt, CNT_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline.
- Watches ID-stage operand usage and the destination fields held in the ID/EX and EX/MEM latches.
- Drives the pipeline latch enables, with ID/EX enable low meaning a bubble (wreg/wmem cleared), the IF/ID flush, and the ALU operand forwarding selects.
- Sequences the multi-cycle multiply/divide unit (MDU) through a small busy FSM, and keeps a stall-cycle performance counter.

Parameters:
MDU_LAT, 4, MDU busy cycles after issue; legal range 1..15
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction is a branch comparing registers in ID
id_taken  in  1  branch/jump in ID redirects PC this cycle
id_mdu_start  in  1  ID instruction is mult/multu/div/divu
id_rd_hilo  in  1  ID instruction is mfhi/mflo
ex_wreg  in  1  ID/EX latch wreg
ex_m2reg  in  1  ID/EX latch m2reg (load)
ex_wn  in  5  ID/EX latch destination register
mem_wreg  in  1  EX/MEM latch wreg
mem_m2reg  in  1  EX/MEM latch m2reg
mem_wn  in  5  EX/MEM latch destination register
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID clear (squash fetched instruction)
idex_en  out  1  ID/EX latch enable; 0 injects bubble
fwda  out  2  operand A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
fwdb  out  2  operand B select, same encoding
mdu_go  out  1  MDU start, valid the cycle the op is latched into ID/EX
mdu_busy  out  1  MDU FSM in BUSY
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (clrn=0, async): FSM=IDLE, busy counter=0, stall_cnt=0. All other outputs are combinational from registered state and inputs.
- Reset values with inputs idle: pc_en=ifid_en=idex_en=1, ifid_flush=0, fwda=fwdb=00, mdu_go=0, mdu_busy=0.
- Reset mid-MDU-op returns to IDLE immediately. No pending stall survives reset.
- Register match: a match requires operand nonzero (r0 never matches) and the corresponding use bit set.
- Forwarding per operand (rs→fwda, rt→fwdb), priority order:
  - EX match with ex_wreg & ~ex_m2reg → 01.
  - Else MEM match with mem_wreg → 10 if ~mem_m2reg, 11 if mem_m2reg.
  - Else 00.
- Stall terms (stall = OR of all):
  - load_use: ex_wreg & ex_m2reg & EX match on either operand.
  - br_haz: id_is_branch & ex_wreg & EX match on either operand. The ALU result is not yet available in ID.
  - mdu_haz: FSM=BUSY & (id_mdu_start | id_rd_hilo).
- stall=1: pc_en=0, ifid_en=0, idex_en=0 (bubble), ifid_flush=0, mdu_go=0. Stall wins over id_taken; the branch re-evaluates next cycle.
- stall=0: pc_en=ifid_en=idex_en=1, ifid_flush=id_taken, mdu_go=id_mdu_start & FSM=IDLE.
- MDU FSM:
  - IDLE: on mdu_go, go to BUSY with cnt=MDU_LAT-1.
  - BUSY: if cnt=0, go to IDLE; else cnt-=1.
  - mdu_busy=1 for exactly MDU_LAT cycles after the issue edge.
  - id_mdu_start in the last BUSY cycle stalls; it issues the following cycle.
- stall_cnt increments on each rising edge where stall=1 and saturates at all-ones.
- Simultaneous load_use and mdu_haz count as one stall cycle.

Test Plan:
- Load-use: ex_wreg=1, ex_m2reg=1, ex_wn=5, id_rs=5, id_use_rs=1 → pc_en=ifid_en=idex_en=0 for one cycle; next cycle same ID with mem_m2reg=1, mem_wn=5 → fwda=11, no stall; stall_cnt=1.
- Forward priority: ex_wn=mem_wn=8, ex_wreg=mem_wreg=1, ex_m2reg=0, id_rt=8, id_use_rt=1 → fwdb=01. Repeat with id_rt=0 → fwdb=00.
- Branch flush vs stall: id_taken=1, no hazard → ifid_flush=1, pc_en=1. Add id_is_branch=1 with ex_wreg=1, ex_wn=id_rs → ifid_flush=0, stall=1 for one cycle, then flush.
- MDU with MDU_LAT=4: id_mdu_start pulse → mdu_go=1, then mdu_busy=1 for 4 cycles. id_rd_hilo held from the next cycle stalls 4 cycles and releases on the 5th; stall_cnt=4.
- Back-to-back MDU: two mult instructions consecutive → second stalls MDU_LAT cycles, then mdu_go=1 exactly once more.
- Async reset mid-BUSY: drop clrn at cycle 2 of busy → mdu_busy=0 and stall_cnt=0 immediately, without a clock edge. Saturation: force 2^CNT_W+3 stall cycles → stall_cnt stays 0xFFFF.
